// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: controller state encoding
// and the MIPS ALU function codes that decode into start / signed_div.
package div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // SPECIAL-opcode function fields for the two divide instructions
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  // EX-stage decode: this function field requests the divider
  function automatic logic is_div_funct(input logic [5:0] funct);
    return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  endfunction

  // EX-stage decode: this function field requests a signed divide
  function automatic logic is_signed_funct(input logic [5:0] funct);
    return funct == FUNCT_DIV;
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring radix-2 divider datapath: operand magnitudes, one quotient bit
// per step, and the sign fix-up of the final quotient/remainder.
// Holds no control state; the controller in div_unit sequences load/step.
module div_core
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               load,
  input  logic               step,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          shifted;
  logic [WIDTH:0]          diff;
  logic [WIDTH-1:0]        rem_step;
  logic [WIDTH-1:0]        quo_step;
  logic                    qbit;

  assign a_s = a;
  assign b_s = b;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (is_signed && (v < 0)) ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Load magnitudes/signs on start, else one shift/trial-subtract per step
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, bmag_q};
    if (!diff[WIDTH]) begin
      rem_step = diff[WIDTH-1:0];
      qbit     = 1'b1;
    end else begin
      rem_step = shifted[WIDTH-1:0];
      qbit     = 1'b0;
    end
    quo_step = {dvd_q[WIDTH-2:0], qbit};

    rem_d  = rem_q;
    dvd_d  = dvd_q;
    bmag_d = bmag_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (load) begin
      rem_d  = '0;
      dvd_d  = mag(a_s, signed_div);
      bmag_d = mag(b_s, signed_div);
      qneg_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_d = signed_div & a[WIDTH-1];
    end else if (step) begin
      rem_d = rem_step;
      dvd_d = quo_step;
    end

    // Signed result of the step in flight; captured by the controller on the last step
    res_o = {neg_if(rem_step, rneg_q), neg_if(quo_step, qneg_q)};
  end

  // Datapath registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    dvd_q  <= dvd_d;
    bmag_q <= bmag_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: IDLE/BUSY/DONE controller,
// pipeline stall/ready handshake and the registered {HI, LO} result.
// Optional feature: define DIV_CANCEL_EN to add the exception-flush cancel port.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef DIV_CANCEL_EN
  input  logic               cancel,
`endif
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               cancel_i;
  logic               b_zero;
  logic               last_iter;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] core_res;

`ifdef DIV_CANCEL_EN
  assign cancel_i = cancel;
`else
  assign cancel_i = 1'b0;
`endif

  assign b_zero    = (b == '0);
  assign last_iter = (cnt_q == CNT_LAST);
  assign load      = (state_q == IDLE) && start && !b_zero && !cancel_i;
  assign step      = (state_q == BUSY) && !cancel_i;
  assign result    = result_q;

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .load       (load),
    .step       (step),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .res_o      (core_res)
  );

  // Controller state, iteration counter and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next state; DONE always returns to IDLE so a held start is the next instruction
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cancel_i)   state_d = IDLE;
        else if (start) state_d = b_zero ? DONE : BUSY;
      end
      BUSY: begin
        if (cancel_i)       state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter and result update; a cancelled divide leaves result untouched
  always_comb begin
    cnt_d    = cnt_q;
    result_d = result_q;
    if (!cancel_i) begin
      if (state_q == IDLE && start) begin
        cnt_d = '0;
        if (b_zero) result_d = {a, {WIDTH{1'b1}}};
      end else if (state_q == BUSY) begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) result_d = core_res;
      end
    end
  end

  // Handshake outputs; stall stays low while reset is asserted
  always_comb begin
    stall = 1'b0;
    ready = 1'b0;
    unique case (state_q)
      IDLE:    stall = start & ~rst;
      BUSY:    stall = 1'b1;
      DONE:    ready = 1'b1;
      default: ;
    endcase
    if (cancel_i) stall = 1'b0;
  end

endmodule
